hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_pkg.sv | 25 ++
 rtl/hilo_div_step.sv | 39 +++
 rtl/hilo_unit.sv | 133 +++++++++++++
 tb/tb_hilo_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared types and constants for the HI/LO register unit:
//                FSM state type, data width, divide iteration count and
//                read-select encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    localparam int DATA_W    = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;

    localparam logic RD_LO = 1'b0;
    localparam logic RD_HI = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } hilo_state_t;

endpackage : hilo_pkg
`default_nettype wire

// File: rtl/hilo_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division step. Shifts {rem, quot} left by one,
//                trial-subtracts the divisor from the widened remainder and
//                either keeps the difference (quotient bit 1) or restores
//                the shifted remainder (quotient bit 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import hilo_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quot,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_nxt,
    output logic [DATA_W-1:0] quot_nxt
);

    logic [DATA_W:0] w_shifted;
    logic [DATA_W:0] w_diff;

    // 33-bit trial subtraction; the sign bit of the difference selects keep or restore.
    // When the restore path is taken the shifted value is below the divisor,
    // so dropping its top bit loses nothing.
    always_comb begin
        w_shifted = {rem, quot[DATA_W-1]};
        w_diff    = w_shifted - {1'b0, divisor};
        if (!w_diff[DATA_W]) begin
            rem_nxt  = w_diff[DATA_W-1:0];
            quot_nxt = {quot[DATA_W-2:0], 1'b1};
        end else begin
            rem_nxt  = w_shifted[DATA_W-1:0];
            quot_nxt = {quot[DATA_W-2:0], 1'b0};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_unit
//  Description : HI/LO register pair. Loads a 64-bit multiply product in one
//                cycle or runs a 32-step unsigned restoring divide, committing
//                remainder to HI and quotient to LO. HI/LO are read through
//                a combinational select.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_unit
    import hilo_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                mul_we,
    input  logic [63:0]         R64,
    input  logic                div_start,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic                rd_sel,
    output logic [DATA_W-1:0]   rd_data,
    output logic                busy,
    output logic                done,
    output logic                dz
);

    hilo_state_t        r_state;
    hilo_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_rem;
    logic [DATA_W-1:0]  r_quot;     // holds the latched dividend before the first step
    logic [DATA_W-1:0]  r_div;      // latched divisor
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic [DATA_W-1:0]  w_rem_nxt;
    logic [DATA_W-1:0]  w_quot_nxt;
    logic               w_last;

    div_step u_div_step (
        .rem      (r_rem),
        .quot     (r_quot),
        .divisor  (r_div),
        .rem_nxt  (w_rem_nxt),
        .quot_nxt (w_quot_nxt)
    );

    assign w_last = (r_cnt == CNT_W'(DIV_ITERS - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs; a divide start always wins over a multiply load.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        dz          = 1'b0;
        case (r_state)
            IDLE: begin
                if (div_start) begin
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                dz          = (r_div == '0);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand latches, iteration counter and HI/LO updates.
    // HI/LO are written only by an idle multiply load or the final divide step,
    // so an aborted divide never leaks a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_start) begin
                        r_rem  <= '0;
                        r_quot <= A;
                        r_div  <= B;
                        r_cnt  <= '0;
                    end else if (mul_we) begin
                        r_hi <= R64[63:32];
                        r_lo <= R64[31:0];
                    end
                end
                DIV: begin
                    r_rem  <= w_rem_nxt;
                    r_quot <= w_quot_nxt;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_rem_nxt;
                        r_lo <= w_quot_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Combinational read port.
    always_comb begin
        rd_data = (rd_sel == RD_HI) ? r_hi : r_lo;
    end

endmodule : hilo_unit
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_unit
//  Description : Scoreboard bench for hilo_unit. Divide expectations come
//                from a plain-arithmetic model (/ and %) and are queued at
//                issue; a monitor pops them on each done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mul_we;
    logic [63:0] R64;
    logic        div_start;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        dz;

    exp_t        exp_q[$];
    int          passed   = 0;
    int          total    = 0;
    int          done_cnt = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    hilo_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mul_we    (mul_we),
        .R64       (R64),
        .div_start (div_start),
        .A         (A),
        .B         (B),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned division semantics, with divide-by-zero defined as
    // remainder = dividend and quotient = all ones.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        if (b == 32'd0) begin
            r.hi = a;
            r.lo = 32'hFFFF_FFFF;
            r.dz = 1'b1;
        end else begin
            r.hi = a % b;
            r.lo = a / b;
            r.dz = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rd_sel = 1'($urandom % 2);
    endtask

    task automatic read_check(input string name, input logic [31:0] hi, input logic [31:0] lo);
        rd_sel = 1'b1;
        #1;
        check({name, "_hi"}, rd_data, hi);
        rd_sel = 1'b0;
        #1;
        check({name, "_lo"}, rd_data, lo);
    endtask

    task automatic do_mul(input logic [63:0] r);
        mul_we = 1'b1;
        R64    = r;
        tick();
        mul_we = 1'b0;
        R64    = 64'($urandom);
        model_hi = r[63:32];
        model_lo = r[31:0];
        check("mul_busy", busy, 1'b0);
        read_check("mul", model_hi, model_lo);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input bit interfere, input bit also_mul, input logic [63:0] mr);
        exp_t        e;
        int          n;
        int          d0;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        pre_hi = model_hi;
        pre_lo = model_lo;
        e  = ref_div(a, b);
        exp_q.push_back(e);
        d0 = done_cnt;
        div_start = 1'b1;
        A         = a;
        B         = b;
        mul_we    = also_mul;
        R64       = mr;
        tick();
        div_start = 1'b0;
        mul_we    = 1'b0;
        A         = $urandom;
        B         = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (interfere) begin
                if (n == 5)  begin mul_we = 1'b1; R64 = 64'h1; end
                if (n == 6)  mul_we = 1'b0;
                if (n == 10) begin div_start = 1'b1; A = 32'd9; B = 32'd3; end
                if (n == 11) div_start = 1'b0;
            end
            if (n == 15) read_check("busy_rd", pre_hi, pre_lo);
            n++;
            tick();
        end
        check("busy_cycles", n, 33);
        check("done_pulses", done_cnt - d0, 1);
        model_hi = e.hi;
        model_lo = e.lo;
        read_check("div_after", model_hi, model_lo);
    endtask

    // Monitor: consumes one expectation per done pulse, then confirms the
    // result is still held on the first idle cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done=1 expected no pending divide");
                end else begin
                    e = exp_q.pop_front();
                    check("mon_dz", dz, e.dz);
                    check("mon_rd_at_done", rd_data, rd_sel ? e.hi : e.lo);
                    @(negedge clk);
                    check("mon_done_once", done, 1'b0);
                    check("mon_rd_after", rd_data, rd_sel ? e.hi : e.lo);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   d0;
        logic [31:0] ra;
        logic [31:0] rb;
        rst       = 1'b1;
        mul_we    = 1'b0;
        R64       = '0;
        div_start = 1'b0;
        A         = '0;
        B         = '0;
        rd_sel    = 1'b0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", dz, 1'b0);
        read_check("rst", 32'd0, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Directed cases.
        do_mul(64'h0000_0002_FFFF_FFFE);
        do_div(32'd100, 32'd7, 1'b0, 1'b0, 64'd0);
        do_div(32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 64'd0);
        do_div(32'd1000, 32'd33, 1'b1, 1'b0, 64'd0);
        do_div(32'd9, 32'd2, 1'b0, 1'b1, 64'h5);
        check("simul_hi", model_hi, 32'd1);
        check("simul_lo", model_lo, 32'd4);

        // Reset in the middle of a divide.
        e  = ref_div(32'd50, 32'd6);
        exp_q.push_back(e);
        d0 = done_cnt;
        div_start = 1'b1;
        A = 32'd50;
        B = 32'd6;
        tick();
        div_start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        read_check("abort", 32'd0, 32'd0);
        e = exp_q.pop_back();
        model_hi = '0;
        model_lo = '0;
        tick();
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check("abort_no_done", done_cnt - d0, 0);
        read_check("abort_hold", 32'd0, 32'd0);
        do_div(32'd15, 32'd4, 1'b0, 1'b0, 64'd0);

        // Randomized mix of multiply loads and divides.
        for (int i = 0; i < 12; i++) begin
            if ($urandom % 3 == 0) begin
                do_mul({$urandom, $urandom});
            end else begin
                ra = $urandom;
                case ($urandom % 4)
                    0:       rb = 32'd0;
                    1:       rb = 32'($urandom_range(1, 15));
                    2:       rb = ra >> $urandom_range(0, 31);
                    default: rb = $urandom;
                endcase
                do_div(ra, rb, ($urandom % 2) == 1, 1'b0, 64'd0);
            end
        end

        repeat (3) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_hilo_unit
`default_nettype wire
